// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
//
// Single-bit full adder. The sum/carry path is purely combinational and
// depends only on the three data inputs, so the cell works as a plain full
// adder with the clock-domain ports tied off. An optional one-stage register
// keeps a copy of the result for bit-serial users, together with a valid flag.
//
// Ports
//   i_clk      in   rising-edge clock for the registered stage
//   i_rst_n    in   asynchronous active-low reset of the registered stage
//   i_a        in   addend A
//   i_b        in   addend B
//   i_cin      in   carry-in
//   i_en       in   capture enable for the registered stage
//   i_clr      in   synchronous clear of the registered stage (beats i_en)
//   o_sum      out  combinational sum       (i_a ^ i_b ^ i_cin)
//   o_carry    out  combinational carry-out (majority of i_a, i_b, i_cin)
//   o_sum_q    out  registered sum
//   o_carry_q  out  registered carry-out
//   o_valid    out  high in the cycle after a capture
// -----------------------------------------------------------------------------
module full_adder_1bit (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sum,
  output logic o_carry,
  output logic o_sum_q,
  output logic o_carry_q,
  output logic o_valid
);

  // Two-bit result of the 1+1+1 addition; the range 0..3 always fits.
  logic [1:0] result;

  assign result  = {1'b0, i_a} + {1'b0, i_b} + {1'b0, i_cin};
  assign o_sum   = result[0];
  assign o_carry = result[1];

  // Registered copy of the result. Clear outranks capture; with neither,
  // the data flops hold and the valid flag drops so it marks only the cycle
  // right after a capture.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum_q   <= 1'b0;
      o_carry_q <= 1'b0;
      o_valid   <= 1'b0;
    end else if (i_clr) begin
      o_sum_q   <= 1'b0;
      o_carry_q <= 1'b0;
      o_valid   <= 1'b0;
    end else if (i_en) begin
      o_sum_q   <= result[0];
      o_carry_q <= result[1];
      o_valid   <= 1'b1;
    end else begin
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder_1bit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_1bit
//
// Directed bench for full_adder_1bit. Expected values come from a truth table
// and a gate-level reference (xor / majority) plus a small model of the
// registered stage; they are pushed to a scoreboard queue when stimulus is
// applied and popped when the corresponding output is sampled.
// -----------------------------------------------------------------------------
module tb_full_adder_1bit;

  logic i_clk;
  logic i_rst_n;
  logic i_a;
  logic i_b;
  logic i_cin;
  logic i_en;
  logic i_clr;
  logic o_sum;
  logic o_carry;
  logic o_sum_q;
  logic o_carry_q;
  logic o_valid;

  logic clk_run;

  int checks;
  int errors;

  logic [2:0] sb[$];

  // Registered-stage model state: {valid, carry_q, sum_q}.
  logic m_sum_q;
  logic m_carry_q;
  logic m_valid;

  full_adder_1bit dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_cin     (i_cin),
    .i_en      (i_en),
    .i_clr     (i_clr),
    .o_sum     (o_sum),
    .o_carry   (o_carry),
    .o_sum_q   (o_sum_q),
    .o_carry_q (o_carry_q),
    .o_valid   (o_valid)
  );

  // Clock can be held idle for the combinational part of the run.
  initial i_clk = 1'b0;
  always begin
    #5;
    if (clk_run) i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Gate-level reference: {carry, sum}.
  function automatic logic [1:0] ref_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the observed value.
  task automatic sb_check(input string tag, input logic [2:0] obs);
    logic [2:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%b expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = sb.pop_front();
      check(tag, obs, exp);
    end
  endtask

  // Drive one set of registered-stage inputs, advance one edge, compare.
  task automatic reg_step(input string tag, input logic en, input logic clr,
                          input logic a, input logic b, input logic c);
    logic [1:0] r;
    i_en  = en;
    i_clr = clr;
    i_a   = a;
    i_b   = b;
    i_cin = c;
    r = ref_add(a, b, c);
    if (clr) begin
      m_sum_q = 1'b0; m_carry_q = 1'b0; m_valid = 1'b0;
    end else if (en) begin
      m_sum_q = r[0]; m_carry_q = r[1]; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    sb.push_back({m_valid, m_carry_q, m_sum_q});
    @(posedge i_clk);
    #1;
    sb_check(tag, {o_valid, o_carry_q, o_sum_q});
  endtask

  logic [1:0] truth [8];
  logic [2:0] v;

  initial begin
    truth = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    checks    = 0;
    errors    = 0;
    clk_run   = 1'b0;
    i_rst_n   = 1'b0;
    i_a       = 1'b0;
    i_b       = 1'b0;
    i_cin     = 1'b0;
    i_en      = 1'b0;
    i_clr     = 1'b0;
    m_sum_q   = 1'b0;
    m_carry_q = 1'b0;
    m_valid   = 1'b0;

    // Reset state of the registered stage.
    sb.push_back(3'b000);
    #5;
    sb_check("reset_state", {o_valid, o_carry_q, o_sum_q});

    // Exhaustive truth table, clock idle and reset still asserted.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {i_a, i_b, i_cin} = v;
      sb.push_back({1'b0, truth[i]});
      #5;
      sb_check($sformatf("exhaustive_%b", v), {1'b0, o_carry, o_sum});
    end

    // Random vectors against the gate-level reference.
    for (int i = 0; i < 100; i++) begin
      v = 3'($urandom_range(0, 7));
      {i_a, i_b, i_cin} = v;
      sb.push_back({1'b0, ref_add(v[2], v[1], v[0])});
      #5;
      sb_check($sformatf("random_%0d_%b", i, v), {1'b0, o_carry, o_sum});
    end

    // Start the clock and leave reset between edges.
    #2;
    i_rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge i_clk);

    // Registered capture then hold.
    reg_step("capture_110", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    reg_step("hold_en0",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear wins over enable.
    reg_step("load_101",    1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    reg_step("clr_over_en", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges.
    reg_step("load_111",    1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    i_rst_n = 1'b0;
    m_sum_q = 1'b0; m_carry_q = 1'b0; m_valid = 1'b0;
    sb.push_back({m_valid, m_carry_q, m_sum_q});
    sb.push_back({1'b0, ref_add(1'b1, 1'b1, 1'b1)});
    #1;
    sb_check("async_reset_regs", {o_valid, o_carry_q, o_sum_q});
    sb_check("async_reset_comb", {1'b0, o_carry, o_sum});
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Back-to-back captures with enable held.
    reg_step("stream_001", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    reg_step("stream_110", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    reg_step("stream_111", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Nothing may be left unchecked in the scoreboard.
    check("scoreboard_drained", 3'(sb.size()), 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
